// File: rtl/seg7_scan_driver_if.sv
// seg7_if: bundles the digit/display signals of seg7_scan_driver.
//   master side (upstream converters / testbench): drives digit0..digit3,
//     blank_lz and dp_mask; observes an, seg, dp and frame_tick.
//   slave side (seg7_scan_driver): samples the inputs, drives the display.
// Handshake: there is none. digit0..3, blank_lz and dp_mask are level
// signals that the driver samples only at its once-per-frame snapshot;
// frame_tick is a one-cycle pulse marking that snapshot, with no ready or
// acknowledge in either direction.
interface seg7_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       blank_lz;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output digit0, digit1, digit2, digit3, blank_lz, dp_mask,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, blank_lz, dp_mask,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four BCD digits onto a 4-digit
// seven-segment display.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : seg7_if.slave
//              in : digit0..digit3 (digit0 rightmost), blank_lz, dp_mask
//              out: an (bit i = digit i), seg {g,f,e,d,c,b,a}, dp,
//                   frame_tick (one-cycle pulse at each frame boundary)
// Each digit owns PRESCALE cycles; the first GUARD cycles of a slot keep all
// anodes off to avoid ghosting. All inputs are captured together once per
// frame so half-updated converter values never tear the display.
module seg7_scan_driver #(
  parameter int PRESCALE   = 50000,
  parameter int GUARD      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_TC    = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PCNT_GUARD = PW'(GUARD);

  // Inactive levels for the registered outputs.
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  // Active-high decode; codes 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;   // {digit3, digit2, digit1, digit0}
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic          shadow_blz_q, shadow_blz_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frame_tick_q, frame_tick_d;

  logic       tc;
  logic       snap;
  logic [3:0] cur_digit;
  logic [3:0] is_zero;
  logic [3:0] lead_zero;
  logic       blank;
  logic [6:0] seg_raw;
  logic [3:0] an_raw;

  always_comb begin
    tc   = (pcnt_q == PCNT_TC);
    snap = tc && (idx_q == 2'd3);

    pcnt_d = tc ? '0 : pcnt_q + PW'(1);
    idx_d  = tc ? idx_q + 2'd1 : idx_q;

    // blank_lz is captured with the digits so blanking only ever changes
    // on a frame boundary.
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_blz_d = shadow_blz_q;
    if (snap) begin
      shadow_d     = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
      shadow_dp_d  = bus.dp_mask;
      shadow_blz_d = bus.blank_lz;
    end
    frame_tick_d = snap;

    // A digit is a leading zero when it and every digit to its left are 0.
    // Digit 0 is never blanked; dash codes are nonzero.
    for (int i = 0; i < 4; i++) begin
      is_zero[i] = (shadow_q[i*4 +: 4] == 4'd0);
    end
    lead_zero[3] = is_zero[3];
    lead_zero[2] = is_zero[3] & is_zero[2];
    lead_zero[1] = is_zero[3] & is_zero[2] & is_zero[1];
    lead_zero[0] = 1'b0;

    cur_digit = shadow_q[idx_q*4 +: 4];
    blank     = shadow_blz_q & lead_zero[idx_q];
    seg_raw   = blank ? 7'h00 : decode(cur_digit);
    an_raw    = (pcnt_q >= PCNT_GUARD) ? (4'b0001 << idx_q) : 4'b0000;

    an_d  = an_raw ^ {4{ACTIVE_LOW}};
    seg_d = seg_raw ^ {7{ACTIVE_LOW}};
    dp_d  = shadow_dp_q[idx_q] ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      shadow_blz_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_blz_q <= shadow_blz_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule
